// File: rtl/vectorgates_unpack_if.sv
// ============================================================================
// vectorgates_unpack_if : valid/ready link into and out of the unpacker
// Rev 1.0 : initial release (optional VECTORGATES_PARITY_EN adds parity pins)
// ============================================================================
`default_nettype none

interface vectorgates_unpack_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_not;
  logic [2:0] in_or_bitwise;
  logic       in_or_logical;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] a;
  logic [2:0] b;
  logic       mismatch;
`ifdef VECTORGATES_PARITY_EN
  logic       in_parity;
  logic       parity_err;
`endif

  modport master (
    output in_valid, in_not, in_or_bitwise, in_or_logical, out_ready,
`ifdef VECTORGATES_PARITY_EN
    output in_parity,
    input  parity_err,
`endif
    input  in_ready, out_valid, a, b, mismatch
  );

  modport slave (
    input  in_valid, in_not, in_or_bitwise, in_or_logical, out_ready,
`ifdef VECTORGATES_PARITY_EN
    input  in_parity,
    output parity_err,
`endif
    output in_ready, out_valid, a, b, mismatch
  );
endinterface

`default_nettype wire

// File: rtl/vectorgates_unpack.sv
// ============================================================================
// vectorgates_unpack : recovers a/b from {~b,~a}, re-checks OR claims, counts
// Rev 1.0 : initial release; optional parity check under VECTORGATES_PARITY_EN
// ============================================================================
`default_nettype none

module vectorgates_unpack #(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  vectorgates_unpack_if.slave bus,
  input  logic             err_clr,
  output logic             halted,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic       out_valid_q;
  logic [2:0] a_q;
  logic [2:0] b_q;
  logic       mismatch_q;

  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] ror;
  logic       bad;
  logic       ready;
  logic       accept;

  assign ra  = ~bus.in_not[2:0];
  assign rb  = ~bus.in_not[5:3];
  assign ror = ra | rb;

`ifdef VECTORGATES_PARITY_EN
  logic par_bad;
  logic parity_err_q;
  assign par_bad = (^bus.in_not) != bus.in_parity;
  assign bad     = (bus.in_or_bitwise != ror) | (bus.in_or_logical != (|ror)) | par_bad;
  assign bus.parity_err = parity_err_q;
`else
  assign bad     = (bus.in_or_bitwise != ror) | (bus.in_or_logical != (|ror));
`endif

  // Gating with reset keeps an upstream handshake from completing on a reset cycle.
  assign ready  = ~reset & (state != HALT) & (~out_valid_q | bus.out_ready);
  assign accept = bus.in_valid & ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.mismatch  = mismatch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      halted      <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= 3'b000;
      b_q         <= 3'b000;
      mismatch_q  <= 1'b0;
      word_count  <= '0;
      err_count   <= '0;
`ifdef VECTORGATES_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        a_q         <= ra;
        b_q         <= rb;
        mismatch_q  <= bad;
`ifdef VECTORGATES_PARITY_EN
        parity_err_q <= par_bad;
`endif
        if (word_count != CNT_MAX) word_count <= word_count + CNT_ONE;
        if (bad && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) state <= ACTIVE;
        end
        ACTIVE: begin
          // A halting word takes priority over a simultaneous err_clr.
          if (accept && bad && STOP_ON_ERR) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (err_clr) begin
            state  <= ACTIVE;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vectorgates_unpack.sv
// Directed bench for vectorgates_unpack: a CNT_W=8 halting unit and a
// CNT_W=2 non-halting unit for counter saturation.
`default_nettype none

module tb_vectorgates_unpack;
  logic clk = 1'b0;
  logic reset;
  logic err_clr;
  logic halted, sat_halted;
  logic [7:0] word_count, err_count;
  logic [1:0] sat_wc, sat_ec;
  int total = 0;
  int bad = 0;

  vectorgates_unpack_if bus ();
  vectorgates_unpack_if sat_bus ();

  vectorgates_unpack #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .err_clr(err_clr),
    .halted(halted), .word_count(word_count), .err_count(err_count)
  );

  vectorgates_unpack #(.CNT_W(2), .STOP_ON_ERR(1'b0)) u_sat (
    .clk(clk), .reset(reset), .bus(sat_bus), .err_clr(err_clr),
    .halted(sat_halted), .word_count(sat_wc), .err_count(sat_ec)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [5:0] n, input logic [2:0] ob, input logic ol);
    bus.in_valid      = v;
    bus.in_not        = n;
    bus.in_or_bitwise = ob;
    bus.in_or_logical = ol;
`ifdef VECTORGATES_PARITY_EN
    bus.in_parity     = ^n;
`endif
  endtask

  task automatic sat_put(input logic v, input logic [5:0] n, input logic [2:0] ob, input logic ol);
    sat_bus.in_valid      = v;
    sat_bus.in_not        = n;
    sat_bus.in_or_bitwise = ob;
    sat_bus.in_or_logical = ol;
`ifdef VECTORGATES_PARITY_EN
    sat_bus.in_parity     = ^n;
`endif
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] ea,
                         input logic [2:0] eb, input logic em);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, "_a"}, {29'd0, bus.a}, {29'd0, ea});
    check({tag, "_b"}, {29'd0, bus.b}, {29'd0, eb});
    check({tag, "_mm"}, {31'd0, bus.mismatch}, {31'd0, em});
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] wc, input logic [7:0] ec,
                         input logic h);
    check({tag, "_wc"}, {24'd0, word_count}, {24'd0, wc});
    check({tag, "_ec"}, {24'd0, err_count}, {24'd0, ec});
    check({tag, "_halt"}, {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    reset = 1'b1;
    err_clr = 1'b0;
    put(1'b0, 6'd0, 3'd0, 1'b0);
    sat_put(1'b0, 6'd0, 3'd0, 1'b0);
    bus.out_ready = 1'b1;
    sat_bus.out_ready = 1'b1;
    step();
    step();
    chk_out("rst", 1'b0, 3'b000, 3'b000, 1'b0);
    chk_cnt("rst", 8'd0, 8'd0, 1'b0);
    reset = 1'b0;
    #1;
    check("idle_ready", {31'd0, bus.in_ready}, 32'd1);

    // good word, then a=b=0 good, then a=b=0 with wrong logical OR (halts)
    put(1'b1, 6'b101010, 3'b111, 1'b1);
    step();
    chk_out("w1", 1'b1, 3'b101, 3'b010, 1'b0);
    chk_cnt("w1", 8'd1, 8'd0, 1'b0);
    put(1'b1, 6'b111111, 3'b000, 1'b0);
    step();
    chk_out("w2", 1'b1, 3'b000, 3'b000, 1'b0);
    chk_cnt("w2", 8'd2, 8'd0, 1'b0);
    put(1'b1, 6'b111111, 3'b000, 1'b1);
    step();
    chk_out("w3", 1'b1, 3'b000, 3'b000, 1'b1);
    chk_cnt("w3", 8'd3, 8'd1, 1'b1);
    check("w3_ready", {31'd0, bus.in_ready}, 32'd0);
    put(1'b0, 6'b111111, 3'b000, 1'b0);
    step();
    chk_out("drain_halt", 1'b0, 3'b000, 3'b000, 1'b1);
    chk_cnt("drain_halt", 8'd3, 8'd1, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr1_halt", {31'd0, halted}, 32'd0);

    // backpressure: one word held, next word stalls until out_ready rises
    bus.out_ready = 1'b0;
    put(1'b1, 6'b110011, 3'b101, 1'b1);
    step();
    chk_out("w4", 1'b1, 3'b100, 3'b001, 1'b0);
    put(1'b1, 6'b011100, 3'b111, 1'b1);
    #1;
    check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    step();
    chk_out("bp_hold", 1'b1, 3'b100, 3'b001, 1'b0);
    chk_cnt("bp_hold", 8'd4, 8'd1, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk_out("w5", 1'b1, 3'b011, 3'b100, 1'b0);
    check("w5_wc", {24'd0, word_count}, 32'd5);
    put(1'b1, 6'b000111, 3'b111, 1'b1);
    step();
    chk_out("w6", 1'b1, 3'b000, 3'b111, 1'b0);
    check("w6_wc", {24'd0, word_count}, 32'd6);

    // bad bitwise claim halts; a good word offered during HALT is refused
    put(1'b1, 6'b000000, 3'b011, 1'b1);
    step();
    chk_out("w7", 1'b1, 3'b111, 3'b111, 1'b1);
    chk_cnt("w7", 8'd7, 8'd2, 1'b1);
    check("w7_ready", {31'd0, bus.in_ready}, 32'd0);
    put(1'b1, 6'b101010, 3'b111, 1'b1);
    step();
    chk_out("halt_drain", 1'b0, 3'b111, 3'b111, 1'b1);
    chk_cnt("halt_drain", 8'd7, 8'd2, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk_cnt("clr2", 8'd7, 8'd2, 1'b0);
    step();
    chk_out("resume", 1'b1, 3'b101, 3'b010, 1'b0);
    chk_cnt("resume", 8'd8, 8'd2, 1'b0);

    // reset with a word in flight
    reset = 1'b1;
    step();
    reset = 1'b0;
    put(1'b0, 6'd0, 3'd0, 1'b0);
    chk_out("mid_rst", 1'b0, 3'b000, 3'b000, 1'b0);
    chk_cnt("mid_rst", 8'd0, 8'd0, 1'b0);

    // CNT_W=2 unit, no halting: 3 bad words then 2 good
    for (int i = 0; i < 5; i++) begin
      sat_put(1'b1, 6'b111111, 3'b000, (i < 3) ? 1'b1 : 1'b0);
      step();
      if (i == 1) begin
        check("sat_wc2", {30'd0, sat_wc}, 32'd2);
        check("sat_ec2", {30'd0, sat_ec}, 32'd2);
      end
    end
    sat_put(1'b0, 6'd0, 3'd0, 1'b0);
    check("sat_wc", {30'd0, sat_wc}, 32'd3);
    check("sat_ec", {30'd0, sat_ec}, 32'd3);
    check("sat_halt", {31'd0, sat_halted}, 32'd0);
    check("sat_ready", {31'd0, sat_bus.in_ready}, 32'd1);

`ifdef VECTORGATES_PARITY_EN
    put(1'b1, 6'b000001, 3'b111, 1'b1);
    bus.in_parity = 1'b0;
    step();
    put(1'b0, 6'd0, 3'd0, 1'b0);
    check("par_err", {31'd0, bus.parity_err}, 32'd1);
    check("par_mm", {31'd0, bus.mismatch}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/vectorgates_unpack.md
Name: vectorgates_unpack

Overview:
Receive-side counterpart of the vector-gates packer. Accepts a stream of packed words {~b, ~a} plus the packer's claimed OR results, recovers a and b, and recomputes bitwise and logical OR. Flags any disagreement and keeps saturating word and error counters. Sits on a valid/ready link between the packer and downstream logic, with a one-stage registered output and a halt-on-error state machine.

Parameters:
CNT_W, 8, width of word_count and err_count (>=2)
STOP_ON_ERR, 1, 1: enter HALT on first mismatch; 0: keep streaming and only count errors

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_not  input  6  packed word {~b[2:0], ~a[2:0]}
in_or_bitwise  input  3  packer's claimed a|b
in_or_logical  input  1  packer's claimed |(a|b)
err_clr  input  1  leave HALT, return to ACTIVE
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts output this cycle
a  output  3  recovered a = ~in_not[2:0]
b  output  3  recovered b = ~in_not[5:3]
mismatch  output  1  registered with a/b; 1 = claimed OR values disagree with the recomputed ones
halted  output  1  state == HALT
word_count  output  CNT_W  accepted words, saturating
err_count  output  CNT_W  mismatching words, saturating

Behaviour:
- Reset (sync, high): out_valid=0, a=0, b=0, mismatch=0, halted=0, word_count=0, err_count=0, state=IDLE.
- Accept: accept = in_valid & in_ready.
- in_ready = (state != HALT) & (~out_valid | out_ready). This is combinational, so full throughput is 1 word/cycle.
- Latency: 1 cycle. On accept, next cycle a, b, mismatch and out_valid=1 are registered.
- If out_valid & out_ready & ~accept, out_valid clears next cycle. a, b and mismatch hold their last values.
- While out_valid & ~out_ready, a, b and mismatch hold stable.
- Mismatch rule: with ra=~in_not[2:0] and rb=~in_not[5:3], mismatch = (in_or_bitwise != (ra|rb)) | (in_or_logical != |(ra|rb)).
- Counters:
  - word_count +1 per accept.
  - err_count +1 per accept with mismatch.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - Both update in the same cycle as the accept.
- FSM:
  - IDLE: on first accept go to ACTIVE.
  - ACTIVE: on an accept with mismatch and STOP_ON_ERR=1, go to HALT next cycle. The erroneous word is still registered and presented.
  - HALT: in_ready=0 and halted=1. A pending output still drains normally. err_clr=1 returns to ACTIVE next cycle. Counters are not cleared.
  - err_clr is ignored in IDLE and ACTIVE.
- Simultaneous events:
  - Output drain and new accept in the same cycle: the register reloads and out_valid stays 1.
  - Mismatching accept while err_clr=1 in ACTIVE: HALT wins.
- Reset mid-stream: an in-flight output word is discarded and no handshake completes that cycle.

Optional Feature:
VECTORGATES_PARITY_EN
- Defined:
  - Adds input in_parity (1 bit), the even parity of in_not.
  - mismatch additionally asserts when (^in_not) != in_parity.
  - Adds output parity_err (1 bit), registered alongside mismatch, reset 0, high only for a parity failure.
- Undefined: no in_parity or parity_err ports, and mismatch is exactly the rule above.

Test Plan:
- Reset, then in_not=6'b101010, in_or_bitwise=3'b111, in_or_logical=1, out_ready=1 -> next cycle out_valid=1, a=3'b101, b=3'b010, mismatch=0, word_count=1, err_count=0.
- in_not=6'b111111 (a=b=0), in_or_bitwise=0, in_or_logical=0 -> mismatch=0. Repeat with in_or_logical=1 -> mismatch=1 and err_count increments.
- out_ready=0 with a word held, in_valid=1 -> in_ready=0. a/b hold and the counters do not move. Raise out_ready -> in_ready=1, the drain and reload happen in one cycle, and back-to-back words go out at 1/cycle.
- STOP_ON_ERR=1: a bad word (in_not=6'b000000, in_or_bitwise=3'b011) -> a=b=3'b111, mismatch=1, halted=1 next cycle, in_ready=0. Pulse err_clr -> halted=0 next cycle and the stream resumes.
- CNT_W=2: 5 good words -> word_count saturates at 3.
- Reset asserted with out_valid=1 -> next cycle out_valid=0, all counters 0, state IDLE.
- With the macro defined: in_not=6'b000001, in_parity=0 -> parity_err=1, mismatch=1.
